mem_req_scheduler: RTL and testbench

Request front-end for `multi_bank_memory`; sits directly upstream of it and drives its write/address/bank/data pins.
- Accepts read/write commands over a valid/ready handshake and queues them in a command FIFO.
- Issues at most one command per cycle to the memory, then captures the registered read data into a response FIFO returned in order.
- Issue is credit-based, so the memory, which cannot stall, never produces read data without a free response slot.

---
 rtl/mem_sched_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/mem_req_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_mem_req_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared constants and word-layout helpers for mem_req_scheduler.
//   Command FIFO word : {we, bank, addr, wdata}  (wdata at bit 0)
//   Response FIFO word: {bank, addr, rdata}      (rdata at bit 0)
//   STAT_WIDTH        : width of the optional issue statistics counters
package mem_sched_pkg;

  localparam int STAT_WIDTH = 16;

  function automatic int cmd_addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int cmd_bank_lsb(input int dw, input int aw);
    return dw + aw;
  endfunction

  function automatic int cmd_we_bit(input int dw, input int aw, input int bw);
    return dw + aw + bw;
  endfunction

  function automatic int cmd_width(input int dw, input int aw, input int bw);
    return dw + aw + bw + 1;
  endfunction

  function automatic int rsp_addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int rsp_bank_lsb(input int dw, input int aw);
    return dw + aw;
  endfunction

  function automatic int rsp_width(input int dw, input int aw, input int bw);
    return dw + aw + bw;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage.
//   clk, rst_n     : clock, asynchronous active-low reset (clears storage too,
//                    so the head word reads as zero after reset)
//   push, wdata    : write request; accepted when not full, or when full with
//                    a simultaneous pop
//   pop, rdata     : read request and current head word (show-ahead)
//   full, empty    : occupancy flags
//   count          : number of stored entries (0..DEPTH)
// DEPTH must be a power of two (pointers wrap naturally) and at least 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one being popped this cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// mem_req_scheduler: request front-end for multi_bank_memory.
// Queues read/write commands, issues at most one per cycle onto the memory
// pins, and returns registered read data in order through a response FIFO.
// Reads are only issued when a response slot is guaranteed, since the memory
// cannot be stalled.
//   req_*   : command handshake (valid/ready) with we/bank/addr/wdata
//   rsp_*   : read response handshake with rdata and echoed bank/addr
//   mem_*   : memory we/bank_sel/addr/din; mem_dout returns one cycle later
//   busy    : command queued, read in flight, or response held
// Optional build macro MEM_SCHED_STATS_EN adds stat_wr_cnt / stat_rd_cnt,
// saturating counts of writes and reads issued to memory.
module mem_req_scheduler
  import mem_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int BANK_WIDTH = 2,
  parameter int CMD_DEPTH  = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [BANK_WIDTH-1:0] req_bank,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [BANK_WIDTH-1:0] rsp_bank,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  mem_we,
  output logic [BANK_WIDTH-1:0] mem_bank_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy
`ifdef MEM_SCHED_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_wr_cnt,
  output logic [STAT_WIDTH-1:0] stat_rd_cnt
`endif
);

  localparam int CMD_W     = cmd_width(DATA_WIDTH, ADDR_WIDTH, BANK_WIDTH);
  localparam int WE_BIT    = cmd_we_bit(DATA_WIDTH, ADDR_WIDTH, BANK_WIDTH);
  localparam int C_BANK_LSB = cmd_bank_lsb(DATA_WIDTH, ADDR_WIDTH);
  localparam int C_ADDR_LSB = cmd_addr_lsb(DATA_WIDTH);
  localparam int RSP_W     = rsp_width(DATA_WIDTH, ADDR_WIDTH, BANK_WIDTH);
  localparam int R_BANK_LSB = rsp_bank_lsb(DATA_WIDTH, ADDR_WIDTH);
  localparam int R_ADDR_LSB = rsp_addr_lsb(DATA_WIDTH);
  localparam int CAW       = $clog2(CMD_DEPTH);
  localparam int RAW       = $clog2(RSP_DEPTH);

  // command FIFO
  logic [CMD_W-1:0] cmd_wdata, cmd_head;
  logic             cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CAW:0]     cmd_count;

  // response FIFO
  logic [RSP_W-1:0] rsp_wdata, rsp_head;
  logic             rsp_pop, rsp_full, rsp_empty;
  logic [RAW:0]     rsp_count;

  // issue / capture pipeline
  logic                  iss_vld_q, iss_vld_d;
  logic                  iss_rd_q, iss_rd_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  mem_we_q, mem_we_d;
  logic [BANK_WIDTH-1:0] mem_bank_q, mem_bank_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic [BANK_WIDTH-1:0] rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic                  head_we;
  logic [1:0]            inflight_rd;
  logic [RAW+1:0]        credit_sum;
  logic                  credit_ok;
  logic                  issue;

  assign req_ready = !cmd_full;
  assign cmd_push  = req_valid && req_ready;
  assign cmd_wdata = {req_we, req_bank, req_addr, req_wdata};

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_push),
    .wdata (cmd_wdata),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  // A read may only leave the queue if every response already held or still
  // travelling through the memory, plus this one, fits in the response FIFO.
  // A pop happening this same cycle is deliberately not counted as a credit.
  assign head_we     = cmd_head[WE_BIT];
  assign inflight_rd = {1'b0, iss_rd_q} + {1'b0, rd_pend_q};
  assign credit_sum  = {1'b0, rsp_count} + {{RAW{1'b0}}, inflight_rd};
  assign credit_ok   = (credit_sum < (RAW+2)'(RSP_DEPTH));
  assign issue       = !cmd_empty && (head_we || credit_ok);
  assign cmd_pop     = issue;

  always_comb begin
    iss_vld_d  = issue;
    iss_rd_d   = issue && !head_we;
    mem_we_d   = issue && head_we;
    mem_bank_d = mem_bank_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (issue) begin
      mem_bank_d = cmd_head[C_BANK_LSB +: BANK_WIDTH];
      mem_addr_d = cmd_head[C_ADDR_LSB +: ADDR_WIDTH];
      mem_din_d  = cmd_head[0 +: DATA_WIDTH];
    end
    // mem_* may already carry the next command when dout arrives, so the
    // read's bank/addr are carried alongside for the echo.
    rd_pend_d = iss_rd_q;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    if (iss_rd_q) begin
      rd_bank_d = mem_bank_q;
      rd_addr_d = mem_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_vld_q  <= 1'b0;
      iss_rd_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_bank_q <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rd_bank_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      iss_vld_q  <= iss_vld_d;
      iss_rd_q   <= iss_rd_d;
      rd_pend_q  <= rd_pend_d;
      mem_we_q   <= mem_we_d;
      mem_bank_q <= mem_bank_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rd_bank_q  <= rd_bank_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_bank_sel = mem_bank_q;
  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;

  assign rsp_wdata = {rd_bank_q, rd_addr_q, mem_dout};
  assign rsp_pop   = rsp_ready && !rsp_empty;

  sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_pend_q),
    .wdata (rsp_wdata),
    .pop   (rsp_pop),
    .rdata (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  // Credit accounting must never let captured read data hit a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(rd_pend_q && rsp_full && !rsp_pop));

  assign rsp_valid = !rsp_empty;
  assign rsp_rdata = rsp_head[0 +: DATA_WIDTH];
  assign rsp_addr  = rsp_head[R_ADDR_LSB +: ADDR_WIDTH];
  assign rsp_bank  = rsp_head[R_BANK_LSB +: BANK_WIDTH];

  assign busy = (cmd_count != '0) || iss_vld_q || rd_pend_q || !rsp_empty;

`ifdef MEM_SCHED_STATS_EN
  logic [STAT_WIDTH-1:0] stat_wr_q, stat_wr_d;
  logic [STAT_WIDTH-1:0] stat_rd_q, stat_rd_d;

  always_comb begin
    stat_wr_d = stat_wr_q;
    stat_rd_d = stat_rd_q;
    if (mem_we_q && (stat_wr_q != '1)) stat_wr_d = stat_wr_q + STAT_WIDTH'(1);
    if (iss_rd_q && (stat_rd_q != '1)) stat_rd_d = stat_rd_q + STAT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      stat_wr_q <= stat_wr_d;
      stat_rd_q <= stat_rd_d;
    end
  end

  assign stat_wr_cnt = stat_wr_q;
  assign stat_rd_cnt = stat_rd_q;
`endif

endmodule

// File: tb/tb_mem_req_scheduler.sv
// tb_mem_req_scheduler: randomized bench for mem_req_scheduler with a
// behavioural memory and an in-order expected-response queue built from a
// shadow copy of memory contents at command-accept time.
module tb_mem_req_scheduler;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int BW = 2;
  typedef logic [BW+AW+DW-1:0] rsp_word_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [BW-1:0] req_bank;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [BW-1:0] rsp_bank;
  logic [AW-1:0] rsp_addr;
  logic          mem_we;
  logic [BW-1:0] mem_bank_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          busy;
`ifdef MEM_SCHED_STATS_EN
  logic [15:0]   stat_wr_cnt, stat_rd_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_req_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_bank     (req_bank),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_bank     (rsp_bank),
    .rsp_addr     (rsp_addr),
    .mem_we       (mem_we),
    .mem_bank_sel (mem_bank_sel),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout),
    .busy         (busy)
`ifdef MEM_SCHED_STATS_EN
    ,
    .stat_wr_cnt  (stat_wr_cnt),
    .stat_rd_cnt  (stat_rd_cnt)
`endif
  );

  // Environment: multi-bank memory with a one-cycle registered read.
  logic [DW-1:0] mem_arr [4][16];
  logic          mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 16; j++) mem_arr[i][j] <= '0;
    end else if (mem_we) begin
      mem_arr[mem_bank_sel][mem_addr] <= mem_din;
    end
    mem_dout <= mem_arr[mem_bank_sel][mem_addr];
  end

  int cyc = 0;
  int we_pulses = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_we === 1'b1) we_pulses <= we_pulses + 1;

  // Reference: program-order memory image and expected responses.
  logic [DW-1:0] shadow [4][16];
  rsp_word_t     exp_q [$];

  // One cycle: drive inputs at the falling edge; handshakes complete at the
  // next rising edge. Reports accept/pop and the response vs. its expectation.
  task automatic tick(input logic v, input logic we, input logic [BW-1:0] b,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic rr, output logic acc, output logic popped,
                      output rsp_word_t got, output rsp_word_t exp);
    @(negedge clk);
    req_valid = v; req_we = we; req_bank = b; req_addr = a; req_wdata = d;
    rsp_ready = rr;
    acc    = v && (req_ready === 1'b1);
    popped = (rsp_valid === 1'b1) && rr;
    got    = {rsp_bank, rsp_addr, rsp_rdata};
    exp    = 'x;
    if (popped && exp_q.size() > 0) exp = exp_q.pop_front();
    if (acc) begin
      if (we) shadow[b][a] = d;
      else    exp_q.push_back({b, a, shadow[b][a]});
    end
  endtask

  task automatic test_reset();
    logic [31:0] obs;
    obs = {req_ready, rsp_valid, rsp_rdata, rsp_bank, rsp_addr, mem_we,
           mem_bank_sel, mem_addr, mem_din, busy};
    vectors++;
    if (obs !== 32'h8000_0000) begin
      $display("FAIL reset_outputs_in_reset: got %h want 80000000", obs); miscompares++;
    end
    @(negedge clk); rst_n = 1'b1; mem_clr = 1'b0;
    @(negedge clk);
    obs = {req_ready, rsp_valid, rsp_rdata, rsp_bank, rsp_addr, mem_we,
           mem_bank_sel, mem_addr, mem_din, busy};
    vectors++;
    if (obs !== 32'h8000_0000) begin
      $display("FAIL reset_outputs_after_release: got %h want 80000000", obs); miscompares++;
    end
  endtask

  task automatic test_hazard();
    logic acc0, acc1, pop; rsp_word_t got, exp;
    int n = 0;
    tick(1, 1, 0, 3, 8'h11, 1, acc0, pop, got, exp);
    tick(1, 0, 0, 3, 8'h00, 1, acc1, pop, got, exp);
    vectors++;
    if (!(acc0 && acc1)) begin
      $display("FAIL hazard_accept: got %b%b want 11", acc0, acc1); miscompares++;
    end
    for (int t = 0; t < 20; t++) begin
      tick(0, 0, 0, 0, 0, 1, acc0, pop, got, exp);
      if (pop) begin
        n++; vectors++;
        if (got !== {2'd0, 4'd3, 8'h11}) begin
          $display("FAIL hazard_data: got %h want %h", got, {2'd0, 4'd3, 8'h11}); miscompares++;
        end
      end
    end
    vectors++;
    if (n != 1) begin
      $display("FAIL hazard_rsp_count: got %0d want 1", n); miscompares++;
    end
  endtask

  task automatic test_write_read();
    logic acc, pop; rsp_word_t got, exp;
    int w0, acc_edge, we_idx = -1, n = 0;
    w0 = we_pulses;
    tick(1, 1, 2, 5, 8'hA5, 1, acc, pop, got, exp);
    acc_edge = cyc + 1;
    vectors++;
    if (!acc) begin $display("FAIL wr_accept: got 0 want 1"); miscompares++; end
    tick(1, 0, 2, 5, 8'h00, 1, acc, pop, got, exp);
    for (int t = 0; t < 20; t++) begin
      if (mem_we === 1'b1 && we_idx < 0) we_idx = cyc - acc_edge + 1;
      tick(0, 0, 0, 0, 0, 1, acc, pop, got, exp);
      if (pop) begin
        n++; vectors++;
        if (got !== exp || got !== {2'd2, 4'd5, 8'hA5}) begin
          $display("FAIL wr_rd_data: got %h want %h", got, {2'd2, 4'd5, 8'hA5}); miscompares++;
        end
      end
    end
    vectors++;
    if (we_idx != 2) begin
      $display("FAIL wr_mem_we_cycle: got %0d want 2", we_idx); miscompares++;
    end
    vectors++;
    if (we_pulses - w0 != 1) begin
      $display("FAIL wr_we_pulses: got %0d want 1", we_pulses - w0); miscompares++;
    end
    vectors++;
    if (n != 1) begin $display("FAIL wr_rd_rsp_count: got %0d want 1", n); miscompares++; end
  endtask

  task automatic test_back_to_back();
    logic acc, pop, v; rsp_word_t got, exp;
    int n_acc = 0, n_rsp = 0, stalls = 0, gaps = 0, first = -1, last = -1, acc_edge = 0;
    for (int t = 0; t < 40; t++) begin
      v = (n_acc < 8);
      tick(v, 0, BW'($urandom), AW'($urandom), 0, 1, acc, pop, got, exp);
      if (v && !acc) stalls++;
      if (acc) begin
        if (n_acc == 0) acc_edge = cyc + 1;
        n_acc++;
      end
      if (pop) begin
        vectors++;
        if (got !== exp) begin
          $display("FAIL b2b_data[%0d]: got %h want %h", n_rsp, got, exp); miscompares++;
        end
        if (first < 0) first = cyc - acc_edge + 1;
        else if (cyc != last + 1) gaps++;
        last = cyc; n_rsp++;
      end
    end
    vectors++;
    if (stalls != 0) begin $display("FAIL b2b_req_stalls: got %0d want 0", stalls); miscompares++; end
    vectors++;
    if (first != 4) begin $display("FAIL b2b_latency: got %0d want 4", first); miscompares++; end
    vectors++;
    if (gaps != 0) begin $display("FAIL b2b_gaps: got %0d want 0", gaps); miscompares++; end
    vectors++;
    if (n_rsp != 8) begin $display("FAIL b2b_rsp_count: got %0d want 8", n_rsp); miscompares++; end
  endtask

  task automatic test_backpressure();
    logic acc, pop; rsp_word_t got, exp;
    int n_acc = 0, n_rsp = 0;
    for (int t = 0; t < 30; t++) begin
      tick(1, 0, BW'($urandom), AW'($urandom), 0, 0, acc, pop, got, exp);
      if (acc) n_acc++;
    end
    vectors++;
    if (n_acc != 8) begin $display("FAIL bp_accepts: got %0d want 8", n_acc); miscompares++; end
    vectors++;
    if (req_ready !== 1'b0) begin $display("FAIL bp_req_ready: got %b want 0", req_ready); miscompares++; end
    vectors++;
    if (dut.rsp_count !== 3'd4) begin
      $display("FAIL bp_held_rsp: got %0d want 4", dut.rsp_count); miscompares++;
    end
    for (int t = 0; t < 40; t++) begin
      tick(0, 0, 0, 0, 0, 1, acc, pop, got, exp);
      if (pop) begin
        vectors++;
        if (got !== exp) begin
          $display("FAIL bp_data[%0d]: got %h want %h", n_rsp, got, exp); miscompares++;
        end
        n_rsp++;
      end
    end
    vectors++;
    if (n_rsp != 8) begin $display("FAIL bp_rsp_count: got %0d want 8", n_rsp); miscompares++; end
  endtask

  task automatic test_random();
    logic acc, pop, v, we, rr; rsp_word_t got, exp;
    int w0, n_wr = 0;
    w0 = we_pulses;
    for (int t = 0; t < 360; t++) begin
      v  = (t < 300) && ($urandom_range(9) < 7);
      we = $urandom_range(1);
      rr = (t >= 300) || ($urandom_range(9) < 6);
      tick(v, we, BW'($urandom), AW'($urandom), DW'($urandom), rr, acc, pop, got, exp);
      if (acc && we) n_wr++;
      if (pop) begin
        vectors++;
        if (got !== exp) begin
          $display("FAIL rand_data: got %h want %h", got, exp); miscompares++;
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      $display("FAIL rand_drain: got pending=%0d busy=%b want 0 0", exp_q.size(), busy); miscompares++;
    end
    vectors++;
    if (we_pulses - w0 != n_wr) begin
      $display("FAIL rand_we_pulses: got %0d want %0d", we_pulses - w0, n_wr); miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    logic acc, pop; rsp_word_t got, exp;
    logic [31:0] obs;
    int seen = 0;
    tick(1, 0, 1, 7, 0, 1, acc, pop, got, exp);
    tick(1, 0, 1, 7, 0, 1, acc, pop, got, exp);
    tick(0, 0, 0, 0, 0, 1, acc, pop, got, exp);
    tick(0, 0, 0, 0, 0, 1, acc, pop, got, exp);
    #2 rst_n = 1'b0;
    #1;
    obs = {req_ready, rsp_valid, rsp_rdata, rsp_bank, rsp_addr, mem_we,
           mem_bank_sel, mem_addr, mem_din, busy};
    vectors++;
    if (obs !== 32'h8000_0000) begin
      $display("FAIL reset_mid_async: got %h want 80000000", obs); miscompares++;
    end
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete();
    for (int t = 0; t < 12; t++) begin
      tick(0, 0, 0, 0, 0, 1, acc, pop, got, exp);
      if (rsp_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0 || busy !== 1'b0) begin
      $display("FAIL reset_mid_quiet: got rsp_cycles=%0d busy=%b want 0 0", seen, busy); miscompares++;
    end
  endtask

`ifdef MEM_SCHED_STATS_EN
  task automatic test_stats();
    logic acc, pop; rsp_word_t got, exp;
    int n = 0;
    for (int t = 0; t < 40; t++) begin
      tick(n < 8, n < 3, BW'($urandom), AW'($urandom), DW'($urandom), 1, acc, pop, got, exp);
      if (acc) n++;
    end
    vectors++;
    if (stat_wr_cnt !== 16'd3 || stat_rd_cnt !== 16'd5) begin
      $display("FAIL stats_counts: got wr=%0d rd=%0d want 3 5", stat_wr_cnt, stat_rd_cnt); miscompares++;
    end
    n = 0;
    for (int t = 0; t < 71000 && n < 70000; t++) begin
      tick(1, 1, BW'($urandom), AW'($urandom), DW'($urandom), 1, acc, pop, got, exp);
      if (acc) n++;
    end
    for (int t = 0; t < 6; t++) tick(0, 0, 0, 0, 0, 1, acc, pop, got, exp);
    vectors++;
    if (stat_wr_cnt !== 16'hFFFF || stat_rd_cnt !== 16'd5) begin
      $display("FAIL stats_saturate: got wr=%h rd=%0d want ffff 5", stat_wr_cnt, stat_rd_cnt); miscompares++;
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_bank = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 16; j++) shadow[i][j] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_hazard();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef MEM_SCHED_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
